// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Takes a byte on a valid/ready handshake and shifts it out as
// start bit, DATA_WIDTH data bits (LSB first), optional parity and
// STOP_BITS stop bits. Each bit lasts CLK_DIV clock cycles. The line
// output is registered and idles high.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
  localparam logic              PAR_SEED  = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BAUD_W-1:0]     baud_d;
  logic [BIT_W-1:0]      bit_q;
  logic [STOP_W-1:0]     stop_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_end;

  // Baud counter next value; a bit period ends when the counter hits CLK_DIV-1.
  always_comb begin
    bit_end = (baud_q == BAUD_LAST);
    baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
  end

  // Frame sequencer; tx and busy are registered so tx_q is set to the value
  // of the upcoming bit on the edge that enters each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          if (valid_in) begin
            shift_q <= data_i;
            // Parity comes from the captured byte so it does not depend on
            // how far the shift register has advanced.
            par_q   <= (^data_i) ^ PAR_SEED;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        ST_START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end

        ST_DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (HAS_PAR) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
              tx_q    <= shift_q[1];
            end
          end
        end

        ST_PARITY: begin
          baud_q <= baud_d;
          if (bit_end) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end

        ST_STOP: begin
          baud_q <= baud_d;
          tx_q   <= 1'b1;
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              stop_q  <= '0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= stop_q + STOP_W'(1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          stop_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_in = (state_q == ST_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover 8N1,
// even/odd parity at CLK_DIV=4 and 8N2 at CLK_DIV=16.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0][7:0] data_v;
  logic [3:0]      valid_v;
  wire  [3:0]      ready_v;
  wire  [3:0]      tx_v;
  wire  [3:0]      busy_v;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data_i(data_v[0]), .valid_in(valid_v[0]),
    .ready_in(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  uart_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .data_i(data_v[1]), .valid_in(valid_v[1]),
    .ready_in(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  uart_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data_i(data_v[2]), .valid_in(valid_v[2]),
    .ready_in(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

  uart_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .data_i(data_v[3]), .valid_in(valid_v[3]),
    .ready_in(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_now(input int idx, input string tag);
    check({tag, ".tx"},    32'(tx_v[idx]),    32'd1);
    check({tag, ".busy"},  32'(busy_v[idx]),  32'd0);
    check({tag, ".ready"}, 32'(ready_v[idx]), 32'd1);
  endtask

  task automatic check_idle(input int idx, input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      check_idle_now(idx, tag);
      tick();
    end
  endtask

  task automatic check_idle_all(input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      for (int j = 0; j < 4; j++) check_idle_now(j, tag);
      tick();
    end
  endtask

  // Start one cycle after the handshake edge; seq lists line bits in
  // transmit order, leftmost first. Optional poke pulses valid with 0x3C
  // at frame cycle 'poke' and then scrambles data_i.
  task automatic expect_frame(input int idx, input logic [15:0] seq, input int nbits,
                              input int div, input int poke, input string tag);
    int cyc;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < div; c++) begin
        cyc = k * div + c;
        if (poke >= 0 && cyc == poke) begin
          valid_v[idx] = 1'b1;
          data_v[idx]  = 8'h3C;
        end
        if (poke >= 0 && cyc == poke + 1) begin
          valid_v[idx] = 1'b0;
          data_v[idx]  = 8'hFF;
        end
        check({tag, ".tx"},    32'(tx_v[idx]),    32'(seq[nbits-1-k]));
        check({tag, ".busy"},  32'(busy_v[idx]),  32'd1);
        check({tag, ".ready"}, 32'(ready_v[idx]), 32'd0);
        tick();
      end
    end
  endtask

  task automatic handshake(input int idx, input logic [7:0] b, input string tag);
    data_v[idx]  = b;
    valid_v[idx] = 1'b1;
    check({tag, ".ready_hs"}, 32'(ready_v[idx]), 32'd1);
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    valid_v = '0;
    data_v  = '0;
    tick();
    tick();
    for (int j = 0; j < 4; j++) check_idle_now(j, "reset");
    rst = 1'b0;
    tick();

    check_idle_all(100, "idle100");

    // 8N1 0xA5: 0,10100101,1; data_i changed right after capture
    handshake(0, 8'hA5, "a5");
    valid_v[0] = 1'b0;
    data_v[0]  = 8'h00;
    expect_frame(0, 16'b0101001011, 10, 4, -1, "a5");
    check_idle(0, 8, "a5_after");

    // Even parity on 0xA5 (four ones) -> parity bit 0
    handshake(1, 8'hA5, "a5e");
    valid_v[1] = 1'b0;
    expect_frame(1, 16'b01010010101, 11, 4, -1, "a5e");
    check_idle(1, 4, "a5e_after");

    // Odd parity on 0xA5 -> parity bit 1
    handshake(2, 8'hA5, "a5o");
    valid_v[2] = 1'b0;
    expect_frame(2, 16'b01010010111, 11, 4, -1, "a5o");
    check_idle(2, 4, "a5o_after");

    // Back-to-back 0x00 then 0xFF with valid held high
    handshake(0, 8'h00, "b2b0");
    data_v[0] = 8'hFF;
    expect_frame(0, 16'b0000000001, 10, 4, -1, "b2b0");
    check_idle_now(0, "b2b_gap");
    tick();
    valid_v[0] = 1'b0;
    expect_frame(0, 16'b0111111111, 10, 4, -1, "b2b1");
    check_idle(0, 20, "b2b_after");

    // 0x0F with a 0x3C pulse while busy; must not alter or add a frame
    handshake(0, 8'h0F, "busy");
    valid_v[0] = 1'b0;
    expect_frame(0, 16'b0111100001, 10, 4, 10, "busy");
    check_idle(0, 30, "busy_after");

    // 8N2 at CLK_DIV=16, 0xC3: 0,11000011,1,1 -> 176 cycles
    handshake(3, 8'hC3, "n2");
    valid_v[3] = 1'b0;
    expect_frame(3, 16'b01100001111, 11, 16, -1, "n2");
    check_idle(3, 5, "n2_after");

    // Reset mid data bit of a 0x00 frame: line must go high at once
    handshake(3, 8'h00, "rstmid");
    valid_v[3] = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("rstmid.tx_before", 32'(tx_v[3]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_idle_now(3, "rstmid");
    tick();
    rst = 1'b0;
    tick();
    check_idle_all(5, "rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side counterpart of the UART RX buffer path.
- Accepts parallel bytes on a valid/ready stream, typically from the TX FIFO or the APB write path.
- Serializes each byte onto the UART line as start bit, DATA_WIDTH data bits LSB first, optional parity, then stop bit(s).
- Generates its own bit timing from a fixed clock divider.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..8).
- CLK_DIV, 16, clk cycles per UART bit (>=2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  DATA_WIDTH  byte to transmit.
- valid_in  input  1  data_i is valid.
- ready_in  output  1  block can accept a byte this cycle.
- tx  output  1  serial line out, idle high.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, tx=1, busy=0, ready_in=1.
  - Shift register, bit counter and baud counter cleared.
  - Reset asserted mid-frame aborts the frame; tx returns to 1 immediately (async).
- Handshake:
  - A transfer occurs when valid_in && ready_in at a rising clk edge.
  - ready_in = (state==IDLE), combinational from the state register.
  - data_i is captured into a shift register on the handshake cycle. Later changes to data_i have no effect on the frame.
  - valid_in while busy is ignored; the upstream block must hold the byte.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - IDLE: tx=1. On handshake, go to START, load the baud counter with 0 and the shift register with data_i.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: tx=shift[0], held for CLK_DIV cycles. Shift right at each bit boundary. After DATA_WIDTH bits, advance.
  - PARITY: tx = XOR of the captured byte, XOR PARITY_ODD, for CLK_DIV cycles.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then go to IDLE.
- Timing:
  - tx is registered. The first start-bit cycle on tx is the cycle after the handshake edge.
  - Each bit lasts exactly CLK_DIV clk cycles.
  - Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLK_DIV cycles.
  - busy=1 from the cycle after the handshake through the last stop-bit cycle. busy=0 in IDLE.
  - Back-to-back: ready_in rises in the first IDLE cycle after the stop bits. A handshake there starts the next start bit on the following cycle.
  - Minimum gap between frames is 1 clk cycle of tx=1 beyond the stop bits.
- Counters:
  - Baud counter is $clog2(CLK_DIV) bits and counts 0..CLK_DIV-1; the bit boundary is at CLK_DIV-1.
  - Bit counter counts 0..DATA_WIDTH-1, then wraps to 0 on leaving DATA.
  - Stop counter counts STOP_BITS bit periods.
- Parity is computed on the captured byte, not the shifting register, so it is stable for the whole frame.
- No illegal states are reachable. An unused encoding decodes to IDLE with tx=1.

Test Plan:
- Reset then idle; no valid_in for 100 cycles -> tx=1, busy=0, ready_in=1 throughout. Assert rst mid-frame -> tx=1, busy=0 at once.
- CLK_DIV=4, 8N1, send 0xA5 -> tx sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1. Frame is 40 cycles; ready_in returns on cycle 41.
- CLK_DIV=4, PARITY_EN=1, even parity, send 0xA5 -> parity bit 0 after the data bits. Same with PARITY_ODD=1 -> parity bit 1. Frame is 44 cycles.
- Back-to-back: valid_in held high with 0x00 then 0xFF -> second start bit begins exactly 1 idle cycle after the first frame's stop bit. No byte is lost or duplicated.
- valid_in pulsed with 0x3C mid-frame while busy -> ignored; the current frame is unchanged and no extra frame follows. Changing data_i mid-frame leaves tx bits unchanged.
- STOP_BITS=2, CLK_DIV=16 -> stop phase lasts 32 cycles at tx=1; total 8N2 frame is 176 cycles.
